// File: rtl/sfx_pkg.sv
// rtl/sfx_pkg.sv - effect ids, FSM states, note record and constant effect tables
package sfx_pkg;

   typedef enum logic [1:0] {
      SFX_NONE   = 2'd0,
      SFX_JUMP   = 2'd1,
      SFX_GOAL   = 2'd2,
      SFX_SQUASH = 2'd3
   } sfx_id_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_PLAY = 2'd2
   } state_e;

   typedef struct packed {
      logic [16:0] hp;
      logic [7:0]  dur;
   } note_t;

   // dur==0 is the end marker; goal fills all four slots and ends implicitly.
   function automatic note_t note_lookup(input sfx_id_e id, input logic [1:0] idx);
      note_t n;
      n = '0;
      case ({id, idx})
         {SFX_JUMP,   2'd0}: n = '{hp: 17'd14261, dur: 8'd40};
         {SFX_JUMP,   2'd1}: n = '{hp: 17'd11986, dur: 8'd40};
         {SFX_JUMP,   2'd2}: n = '{hp: 17'd9507,  dur: 8'd60};
         {SFX_GOAL,   2'd0}: n = '{hp: 17'd9507,  dur: 8'd80};
         {SFX_GOAL,   2'd1}: n = '{hp: 17'd0,     dur: 8'd20};
         {SFX_GOAL,   2'd2}: n = '{hp: 17'd9507,  dur: 8'd80};
         {SFX_GOAL,   2'd3}: n = '{hp: 17'd7131,  dur: 8'd200};
         {SFX_SQUASH, 2'd0}: n = '{hp: 17'd28522, dur: 8'd80};
         {SFX_SQUASH, 2'd1}: n = '{hp: 17'd38030, dur: 8'd150};
         default:            n = '0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/sfx_tone_gen.sv
// rtl/sfx_tone_gen.sv - half-period counter and phase toggle; exposes next-cycle phase
module sfx_tone_gen
   import sfx_pkg::*;
#(
   parameter int HP_W = 17
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [HP_W-1:0] hp_i,
   input  logic            restart_i,
   input  logic            en_i,
   output logic            phase_d_o
);

   logic [HP_W-1:0] cnt_q, cnt_d;
   logic            phase_q, phase_d;

   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (restart_i) begin
         cnt_d   = '0;
         phase_d = (hp_i != '0);
      end else if (en_i) begin
         if (hp_i == '0) begin
            cnt_d   = '0;
            phase_d = 1'b0;
         end else if (cnt_q == hp_i - HP_W'(1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
         end else begin
            cnt_d = cnt_q + HP_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   assign phase_d_o = phase_d;

endmodule

// File: rtl/sfx_sequencer.sv
// rtl/sfx_sequencer.sv - latches event pulses, arbitrates by priority and sequences effect notes
module sfx_sequencer
   import sfx_pkg::*;
#(
   parameter int TICK_CYCLES = 25175,
   parameter int HP_W        = 17
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [2:0] evt_i,
   input  logic       mute_i,
   output logic       sound_o,
   output logic       busy_o,
   output logic [1:0] playing_o
);

   localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

   state_e         state_q, state_d;
   logic [2:0]     pending_q, pending_d;
   sfx_id_e        playing_q, playing_d;
   logic [1:0]     idx_q, idx_d;
   logic           wrap_q, wrap_d;
   note_t          note_q, note_d;
   logic [PW-1:0]  presc_q, presc_d;
   logic [7:0]     ticks_q, ticks_d;
   logic           sound_q;

   sfx_id_e        sel_id;
   note_t          fetched;
   logic [2:0]     clr;
   logic           start;
   logic           tick_wrap;
   logic           phase_d;

   always_comb begin
      if (pending_q[2])      sel_id = SFX_SQUASH;
      else if (pending_q[1]) sel_id = SFX_GOAL;
      else if (pending_q[0]) sel_id = SFX_JUMP;
      else                   sel_id = SFX_NONE;
   end

   // wrap_q marks that all four slots were played: treated as an end marker.
   assign fetched   = wrap_q ? '0 : note_lookup(playing_q, idx_q);
   assign tick_wrap = (presc_q == PW'(TICK_CYCLES - 1));

   always_comb begin
      state_d   = state_q;
      playing_d = playing_q;
      idx_d     = idx_q;
      wrap_d    = wrap_q;
      note_d    = note_q;
      presc_d   = presc_q;
      ticks_d   = ticks_q;
      start     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pending_q != 3'b000) start = 1'b1;
         end
         ST_LOAD: begin
            note_d  = fetched;
            presc_d = '0;
            ticks_d = '0;
            if (fetched.dur == 8'd0) begin
               state_d   = ST_IDLE;
               playing_d = SFX_NONE;
            end else begin
               state_d = ST_PLAY;
            end
         end
         ST_PLAY: begin
            presc_d = tick_wrap ? '0 : presc_q + PW'(1);
            ticks_d = ticks_q + {7'd0, tick_wrap};
            if (sel_id > playing_q) begin
               start = 1'b1;
            end else if (ticks_q == note_q.dur) begin
               state_d         = ST_LOAD;
               {wrap_d, idx_d} = {1'b0, idx_q} + 3'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (start) begin
         state_d   = ST_LOAD;
         playing_d = sel_id;
         idx_d     = '0;
         wrap_d    = 1'b0;
      end
   end

   // A new pulse on the bit being cleared this cycle wins.
   assign clr       = start ? {sel_id == SFX_SQUASH, sel_id == SFX_GOAL, sel_id == SFX_JUMP} : 3'b000;
   assign pending_d = (pending_q & ~clr) | evt_i;

   sfx_tone_gen #(.HP_W(HP_W)) u_tone (
      .clk       (clk),
      .reset_n   (reset_n),
      .hp_i      (HP_W'(note_d.hp)),
      .restart_i (state_q == ST_LOAD),
      .en_i      (state_q == ST_PLAY),
      .phase_d_o (phase_d)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         pending_q <= '0;
         playing_q <= SFX_NONE;
         idx_q     <= '0;
         wrap_q    <= 1'b0;
         note_q    <= '0;
         presc_q   <= '0;
         ticks_q   <= '0;
         sound_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         playing_q <= playing_d;
         idx_q     <= idx_d;
         wrap_q    <= wrap_d;
         note_q    <= note_d;
         presc_q   <= presc_d;
         ticks_q   <= ticks_d;
         sound_q   <= phase_d & (state_d == ST_PLAY) & ~mute_i;
      end
   end

   assign sound_o   = sound_q;
   assign busy_o    = (state_q != ST_IDLE);
   assign playing_o = playing_q;

endmodule
